// File: rtl/cuckoo_l7_pkg.sv
// cuckoo_l7_pkg: shared encodings and widths for the L7 cuckoo loader
package cuckoo_l7_pkg;
  localparam int KICK_W = 5;
  localparam logic T1 = 1'b0;
  localparam logic T2 = 1'b1;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_FULL = 2'b01, ST_KICK_FAIL = 2'b10} status_t;
  typedef enum logic [1:0] {IDLE, PAT, CHK, RSP} state_t;
endpackage

// File: rtl/cuckoo_l7_loader_shadow.sv
// cuckoo_shadow_table: per-table occupancy flops plus synchronous-read pointer array
module cuckoo_shadow_table #(
  parameter int AW = 10,
  parameter int PW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [PW-1:0] wr_ptr,
  output logic          rd_valid,
  output logic [PW-1:0] rd_ptr
);
  logic [2**AW-1:0] valid;
  logic [PW-1:0] ptr [2**AW];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (we) valid[wr_addr] <= 1'b1;
      if (rd_en) rd_valid <= valid[rd_addr];
    end
  end
  always_ff @(posedge clk) begin
    if (we) ptr[wr_addr] <= wr_ptr;
    if (rd_en) rd_ptr <= ptr[rd_addr];
  end
endmodule

// File: rtl/cuckoo_l7_loader.sv
// cuckoo_l7_loader: cuckoo insert engine driving the L7 index and pattern RAM write ports
module cuckoo_l7_loader
  import cuckoo_l7_pkg::*;
#(
  parameter int MAX_KICKS = 16,
  parameter int IDX_AW = 10,
  parameter int PTR_W = 9,
  parameter int ENTRY_W = 58
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IDX_AW-1:0]   cmd_hash_t1,
  input  logic [IDX_AW-1:0]   cmd_hash_t2,
  input  logic [ENTRY_W-1:0]  cmd_entry,
  output logic                idx_we,
  output logic [IDX_AW:0]     idx_addr,
  output logic [PTR_W-1:0]    idx_din,
  output logic                pat_we,
  output logic [PTR_W-1:0]    pat_addr,
  output logic [ENTRY_W-1:0]  pat_din,
  output logic                rsp_valid,
  output logic [1:0]          rsp_status,
  output logic [PTR_W-1:0]    rsp_ptr,
  output logic [KICK_W-1:0]   rsp_kicks,
  output logic [PTR_W:0]      fill_count
);
  localparam logic [KICK_W-1:0] MAXK = KICK_W'(MAX_KICKS);
  localparam logic [PTR_W:0] ONE = (PTR_W+1)'(1);
  state_t state, state_n;
  status_t status;
  logic live, tbl, wr, rd1, rd2, v1, v2, probe_valid, kick, accept;
  logic [IDX_AW-1:0] h1, h2, addr, addr_n;
  logic [ENTRY_W-1:0] entry;
  logic [PTR_W-1:0] cur, ptr, p1, p2, probe_ptr;
  logic [KICK_W-1:0] kicks;
  logic [PTR_W:0] fill;
  logic [2*IDX_AW-1:0] keys [2**PTR_W];
  logic [2*IDX_AW-1:0] kh;
  assign accept = cmd_valid & cmd_ready;
  assign probe_valid = tbl ? v2 : v1;
  assign probe_ptr = tbl ? p2 : p1;
  assign kick = probe_valid && kicks < MAXK;
  assign kh = keys[probe_ptr];
  always_comb begin
    state_n = state;
    wr = 1'b0;
    rd1 = 1'b0;
    rd2 = 1'b0;
    addr_n = addr;
    unique case (state)
      IDLE: if (accept) state_n = fill[PTR_W] ? RSP : PAT;
      PAT: begin
        state_n = CHK;
        rd1 = 1'b1;
        addr_n = h1;
      end
      CHK: begin
        wr = !probe_valid || kick;
        state_n = kick ? CHK : RSP;
        rd1 = kick && tbl == T2;
        rd2 = kick && tbl == T1;
        // the evicted key moves to the other table, so fetch its hash for that table
        addr_n = tbl == T1 ? kh[IDX_AW-1:0] : kh[2*IDX_AW-1:IDX_AW];
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      live <= 1'b0;
      status <= ST_OK;
      tbl <= T1;
      h1 <= '0;
      h2 <= '0;
      entry <= '0;
      addr <= '0;
      cur <= '0;
      ptr <= '0;
      kicks <= '0;
      fill <= '0;
    end else begin
      state <= state_n;
      live <= 1'b1;
      addr <= addr_n;
      if (accept) begin
        h1 <= cmd_hash_t1;
        h2 <= cmd_hash_t2;
        entry <= cmd_entry;
        kicks <= '0;
        status <= ST_FULL;
        ptr <= '0;
      end
      if (state == PAT) begin
        cur <= fill[PTR_W-1:0];
        fill <= fill + ONE;
        tbl <= T1;
      end
      if (state == CHK) begin
        if (!probe_valid) begin
          status <= ST_OK;
          ptr <= PTR_W'(fill - ONE);
        end else if (kick) begin
          cur <= probe_ptr;
          kicks <= kicks + KICK_W'(1);
          tbl <= ~tbl;
        end else begin
          status <= ST_KICK_FAIL;
          ptr <= cur;
        end
      end
    end
  end
  always_ff @(posedge clk)
    if (state == PAT) keys[fill[PTR_W-1:0]] <= {h1, h2};
  cuckoo_shadow_table #(.AW(IDX_AW), .PW(PTR_W)) t1 (
    .clk(clk), .rst(rst), .rd_en(rd1), .rd_addr(addr_n),
    .we(wr && tbl == T1), .wr_addr(addr), .wr_ptr(cur),
    .rd_valid(v1), .rd_ptr(p1)
  );
  cuckoo_shadow_table #(.AW(IDX_AW), .PW(PTR_W)) t2 (
    .clk(clk), .rst(rst), .rd_en(rd2), .rd_addr(addr_n),
    .we(wr && tbl == T2), .wr_addr(addr), .wr_ptr(cur),
    .rd_valid(v2), .rd_ptr(p2)
  );
  assign cmd_ready = live && state == IDLE;
  assign pat_we = state == PAT;
  assign pat_addr = pat_we ? fill[PTR_W-1:0] : '0;
  assign pat_din = pat_we ? entry : '0;
  assign idx_we = wr;
  assign idx_addr = wr ? {tbl, addr} : '0;
  assign idx_din = wr ? cur : '0;
  assign rsp_valid = state == RSP;
  assign rsp_status = rsp_valid ? status : 2'b00;
  assign rsp_ptr = rsp_valid ? ptr : '0;
  assign rsp_kicks = rsp_valid ? kicks : '0;
  assign fill_count = fill;
endmodule

// File: tb/tb_cuckoo_l7_loader.sv
// tb_cuckoo_l7_loader: directed and random inserts checked against a table-level cuckoo model
module tb_cuckoo_l7_loader;
  localparam int MK = 4;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ready;
  logic [9:0] cmd_hash_t1 = '0, cmd_hash_t2 = '0;
  logic [57:0] cmd_entry = '0, pat_din;
  logic idx_we, pat_we, rsp_valid;
  logic [10:0] idx_addr;
  logic [8:0] idx_din, pat_addr, rsp_ptr;
  logic [1:0] rsp_status;
  logic [4:0] rsp_kicks;
  logic [9:0] fill_count;
  int vectors = 0, errors = 0;
  int tab [2][1024];
  int kh1 [512], kh2 [512];
  int mfill;
  int qa [$], qd [$];

  always #5 clk = ~clk;

  cuckoo_l7_loader #(.MAX_KICKS(MK)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_hash_t1(cmd_hash_t1), .cmd_hash_t2(cmd_hash_t2), .cmd_entry(cmd_entry),
    .idx_we(idx_we), .idx_addr(idx_addr), .idx_din(idx_din),
    .pat_we(pat_we), .pat_addr(pat_addr), .pat_din(pat_din),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_ptr(rsp_ptr),
    .rsp_kicks(rsp_kicks), .fill_count(fill_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({idx_we, idx_addr, idx_din, pat_we, pat_addr, rsp_valid,
                            rsp_status, rsp_ptr, rsp_kicks, fill_count, cmd_ready}), 64'd0);
    chk({tag, "_pat_din"}, 64'(pat_din), 64'd0);
  endtask

  function automatic void model_reset();
    for (int t = 0; t < 2; t++)
      for (int b = 0; b < 1024; b++) tab[t][b] = -1;
    mfill = 0;
  endfunction

  // Plain cuckoo insert over the two tables; records every index write in order.
  function automatic void model_insert(input int a, input int b, output int st, output int ptr, output int k);
    int slot, cur, tb, bk, ev;
    qa.delete();
    qd.delete();
    k = 0;
    st = 1;
    ptr = 0;
    if (mfill == 512) return;
    slot = mfill;
    mfill++;
    kh1[slot] = a;
    kh2[slot] = b;
    cur = slot;
    tb = 0;
    bk = a;
    for (int it = 0; it <= MK; it++) begin
      if (tab[tb][bk] < 0) begin
        tab[tb][bk] = cur;
        qa.push_back(tb * 1024 + bk);
        qd.push_back(cur);
        st = 0;
        ptr = slot;
        return;
      end
      if (k == MK) begin
        st = 2;
        ptr = cur;
        return;
      end
      ev = tab[tb][bk];
      tab[tb][bk] = cur;
      qa.push_back(tb * 1024 + bk);
      qd.push_back(cur);
      k++;
      cur = ev;
      tb ^= 1;
      bk = tb ? kh2[ev] : kh1[ev];
    end
  endfunction

  task automatic insert(input int a, input int b, input logic [57:0] e, input bit hold);
    int st, ptr, k, cyc, n, slot;
    bit saw;
    slot = mfill;
    model_insert(a, b, st, ptr, k);
    cmd_valid = 1'b1;
    cmd_hash_t1 = 10'(a);
    cmd_hash_t2 = 10'(b);
    cmd_entry = e;
    chk("ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    cyc = 1;
    n = 0;
    saw = 0;
    while (!rsp_valid && cyc < 40) begin
      if (hold) chk("ready_busy", cmd_ready, 0);
      chk("we_exclusive", 64'(pat_we & idx_we), 0);
      if (pat_we) begin
        saw = 1;
        chk("pat_cycle", cyc, 1);
        chk("pat_addr", pat_addr, slot);
        chk("pat_din", pat_din, e);
      end
      if (idx_we) begin
        chk("idx_in_range", 64'(n < qa.size()), 1);
        if (n < qa.size()) begin
          chk("idx_cycle", cyc, 2 + n);
          chk("idx_addr", idx_addr, 64'(qa[n]));
          chk("idx_din", idx_din, 64'(qd[n]));
        end
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_cycle", cyc, st == 1 ? 1 : 3 + k);
    chk("rsp_status", rsp_status, st);
    chk("rsp_ptr", rsp_ptr, ptr);
    chk("rsp_kicks", rsp_kicks, k);
    chk("rsp_no_we", 64'({idx_we, pat_we}), 0);
    chk("pat_seen", 64'(saw), 64'(st != 1));
    chk("idx_count", n, qa.size());
    if (hold) chk("ready_rsp", cmd_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    model_reset();
    @(posedge clk); #1;
    chk_zero("rst_held");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", cmd_ready, 1);
    chk("fill_after_rst", fill_count, 0);
  endtask

  initial begin
    do_reset();
    insert(5, 7, 58'h1234, 0);
    insert(5, 9, 58'h2bcd, 0);
    chk("fill_two", fill_count, 2);

    do_reset();
    for (int i = 0; i < 3; i++) insert(3, 4, 58'(i + 100), 0);
    chk("fill_kickfail", fill_count, 3);

    do_reset();
    insert(11, 12, 58'h1, 1);
    insert(11, 13, 58'h2, 1);
    insert(20, 21, 58'h3, 0);
    cmd_valid = 1'b0;

    do_reset();
    insert(3, 4, 58'h10, 0);
    insert(3, 4, 58'h11, 0);
    cmd_valid = 1'b1;
    cmd_hash_t1 = 10'd3;
    cmd_hash_t2 = 10'd4;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    insert(5, 7, 58'h1234, 0);

    do_reset();
    for (int i = 0; i < 512; i++)
      insert(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
             58'({$urandom(), $urandom()}), 0);
    chk("fill_full", fill_count, 512);
    insert(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 58'h3ff, 0);
    chk("fill_stays", fill_count, 512);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
